// File: rtl/fpu_pkg.sv
// Shared FPU word format, status width and operand-sequencer state encoding.
package fpu_pkg;

   localparam int FP_EXP_BIAS = 31;
   localparam int FP_STATUS_W = 4;

   typedef struct packed {
      logic        sign;
      logic [5:0]  exp;
      logic [24:0] man;
   } fp_word_t;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_ISSUE = 2'd1,
      SEQ_WAIT  = 2'd2,
      SEQ_HOLD  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/fpu_seq_timer.sv
// Loadable 8-bit down-counter that paces the wait for the FPU result.
module fpu_seq_timer (
   input  logic       clock_100kHz,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [7:0] count;

   always_ff @(posedge clock_100kHz or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && count != 8'd0) begin
         count <= count - 8'd1;
      end
   end

   assign zero = (count == 8'd0);

endmodule

// File: rtl/fpu_op_sequencer.sv
// Sequences one operand pair at a time through a fixed-latency FPU.
// Optional transfer counter on op_count when FPU_SEQ_OPCNT_EN is defined.
module fpu_op_sequencer
   import fpu_pkg::*;
#(
   parameter int unsigned LATENCY = 16
) (
   input  logic                   clock_100kHz,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_op_a,
   input  logic [31:0]            in_op_b,
   output logic [31:0]            fpu_op_a,
   output logic [31:0]            fpu_op_b,
   output logic                   fpu_start,
   input  logic [31:0]            fpu_data_in,
   input  logic [FP_STATUS_W-1:0] fpu_status_in,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [31:0]            res_data,
   output logic [FP_STATUS_W-1:0] res_status
`ifdef FPU_SEQ_OPCNT_EN
   ,
   output logic [15:0]            op_count
`endif
);

   localparam logic [1:0] IDLE  = SEQ_IDLE;
   localparam logic [1:0] ISSUE = SEQ_ISSUE;
   localparam logic [1:0] WAIT  = SEQ_WAIT;
   localparam logic [1:0] HOLD  = SEQ_HOLD;

   localparam logic [7:0] LOAD_VAL = 8'(LATENCY - 1);

   logic [1:0] state;
   logic [1:0] state_nxt;
   fp_word_t   op_a_q;
   fp_word_t   op_b_q;
   logic       tmr_zero;
   logic       accept;
   logic       capture;
   logic       xfer;

   assign in_ready  = (state == IDLE) && !reset;
   assign fpu_start = (state == ISSUE);
   assign res_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;
   assign capture   = (state == WAIT) && tmr_zero;
   assign xfer      = (state == HOLD) && res_ready;
   assign fpu_op_a  = op_a_q;
   assign fpu_op_b  = op_b_q;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)   state_nxt = ISSUE;
         ISSUE:                 state_nxt = WAIT;
         WAIT:    if (tmr_zero) state_nxt = HOLD;
         HOLD:    if (xfer)     state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock_100kHz or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operands stay on the FPU inputs until the next pair is accepted.
   always_ff @(posedge clock_100kHz or posedge reset) begin
      if (reset) begin
         op_a_q     <= '0;
         op_b_q     <= '0;
         res_data   <= '0;
         res_status <= '0;
      end else begin
         if (accept) begin
            op_a_q <= fp_word_t'(in_op_a);
            op_b_q <= fp_word_t'(in_op_b);
         end
         if (capture) begin
            res_data   <= fpu_data_in;
            res_status <= fpu_status_in;
         end
      end
   end

   fpu_seq_timer u_timer (
      .clock_100kHz (clock_100kHz),
      .reset        (reset),
      .load         (state == ISSUE),
      .load_val     (LOAD_VAL),
      .dec          (state == WAIT),
      .zero         (tmr_zero)
   );

`ifdef FPU_SEQ_OPCNT_EN
   always_ff @(posedge clock_100kHz or posedge reset) begin
      if (reset) begin
         op_count <= '0;
      end else if (xfer && op_count != 16'hFFFF) begin
         op_count <= op_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench: two sequencers (LATENCY 16 and 1) against a timing model.
module tb_fpu_op_sequencer;

   localparam int N = 2;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  s;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst [N];
   logic        iv  [N];
   logic        ir  [N];
   logic [31:0] ia  [N];
   logic [31:0] ib  [N];
   logic [31:0] fa  [N];
   logic [31:0] fb  [N];
   logic        fs  [N];
   logic [31:0] fd  [N];
   logic [3:0]  fst [N];
   logic        rv  [N];
   logic        rr  [N];
   logic [31:0] rd  [N];
   logic [3:0]  rs  [N];
`ifdef FPU_SEQ_OPCNT_EN
   logic [15:0] oc  [N];
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int fcnt [N];

   exp_t sb [N][$];
   bit   busy [N];
   bit   b2b  [N];
   int   acc_edge [N];
   int   b2b_last [N];
   int   xfers [N];
   logic [31:0] ea [N];
   logic [31:0] eb [N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat(input int k);
      return (k == 0) ? 16 : 1;
   endfunction

   // FPU behaviour: 1.0 * 2.0 style directed case, otherwise a mixing function.
   function automatic logic [31:0] fres(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3E000000 && b == 32'h40000000) return 32'h40800000;
      return a ^ {b[15:0], b[31:16]} ^ 32'h13579BDF;
   endfunction

   function automatic logic [3:0] fstat(input logic [31:0] a, input logic [31:0] b);
      return a[3:0] ^ b[7:4];
   endfunction

   // The FPU output is only meaningful in the cycle LATENCY cycles after start.
   always @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (fs[k]) fcnt[k] <= 1;
         else if (fcnt[k] < 1000) fcnt[k] <= fcnt[k] + 1;
      end
   end

   assign fd[0]  = (fcnt[0] == 16) ? fres(fa[0], fb[0]) : 32'hBAD00000 | 32'(fcnt[0]);
   assign fst[0] = (fcnt[0] == 16) ? fstat(fa[0], fb[0]) : 4'hF ^ fa[0][3:0];
   assign fd[1]  = (fcnt[1] == 1) ? fres(fa[1], fb[1]) : 32'hBAD00000 | 32'(fcnt[1]);
   assign fst[1] = (fcnt[1] == 1) ? fstat(fa[1], fb[1]) : 4'hF ^ fa[1][3:0];

   fpu_op_sequencer #(.LATENCY(16)) u_dut16 (
      .clock_100kHz  (clk),
      .reset         (rst[0]),
      .in_valid      (iv[0]),
      .in_ready      (ir[0]),
      .in_op_a       (ia[0]),
      .in_op_b       (ib[0]),
      .fpu_op_a      (fa[0]),
      .fpu_op_b      (fb[0]),
      .fpu_start     (fs[0]),
      .fpu_data_in   (fd[0]),
      .fpu_status_in (fst[0]),
      .res_valid     (rv[0]),
      .res_ready     (rr[0]),
      .res_data      (rd[0]),
      .res_status    (rs[0])
`ifdef FPU_SEQ_OPCNT_EN
      ,
      .op_count      (oc[0])
`endif
   );

   fpu_op_sequencer #(.LATENCY(1)) u_dut1 (
      .clock_100kHz  (clk),
      .reset         (rst[1]),
      .in_valid      (iv[1]),
      .in_ready      (ir[1]),
      .in_op_a       (ia[1]),
      .in_op_b       (ib[1]),
      .fpu_op_a      (fa[1]),
      .fpu_op_b      (fb[1]),
      .fpu_start     (fs[1]),
      .fpu_data_in   (fd[1]),
      .fpu_status_in (fst[1]),
      .res_valid     (rv[1]),
      .res_ready     (rr[1]),
      .res_data      (rd[1]),
      .res_status    (rs[1])
`ifdef FPU_SEQ_OPCNT_EN
      ,
      .op_count      (oc[1])
`endif
   );

   task automatic chk(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] cyc %0d: got %h expected %h", nm, k, cyc, act, exp);
      end
   endtask

   // Monitor: check current outputs against the model, then advance the model.
   initial begin
      for (int k = 0; k < N; k++) begin
         busy[k] = 0; b2b[k] = 0; b2b_last[k] = -1; xfers[k] = 0;
         ea[k] = '0; eb[k] = '0; acc_edge[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (rst[k]) begin
               chk("rst_in_ready", k, 32'(ir[k]), 32'd0);
               chk("rst_fpu_start", k, 32'(fs[k]), 32'd0);
               chk("rst_res_valid", k, 32'(rv[k]), 32'd0);
               chk("rst_fpu_op_a", k, fa[k], 32'd0);
               chk("rst_fpu_op_b", k, fb[k], 32'd0);
               chk("rst_res_data", k, rd[k], 32'd0);
               chk("rst_res_status", k, 32'(rs[k]), 32'd0);
`ifdef FPU_SEQ_OPCNT_EN
               chk("rst_op_count", k, 32'(oc[k]), 32'd0);
`endif
               busy[k] = 0; sb[k].delete(); xfers[k] = 0;
               ea[k] = '0; eb[k] = '0; b2b_last[k] = -1;
            end else begin
               bit exp_rv;
               exp_rv = busy[k] && (cyc >= acc_edge[k] + lat(k) + 1);
               chk("in_ready", k, 32'(ir[k]), 32'(!busy[k]));
               chk("fpu_start", k, 32'(fs[k]), 32'(busy[k] && cyc == acc_edge[k]));
               chk("res_valid", k, 32'(rv[k]), 32'(exp_rv));
               chk("fpu_op_a", k, fa[k], ea[k]);
               chk("fpu_op_b", k, fb[k], eb[k]);
`ifdef FPU_SEQ_OPCNT_EN
               chk("op_count", k, 32'(oc[k]), (xfers[k] > 65535) ? 32'hFFFF : 32'(xfers[k]));
`endif
               if (exp_rv) begin
                  if (sb[k].size() == 0) begin
                     chk("scoreboard_empty", k, 32'd0, 32'd1);
                  end else begin
                     chk("res_data", k, rd[k], sb[k][0].d);
                     chk("res_status", k, 32'(rs[k]), 32'(sb[k][0].s));
                  end
               end
               if (exp_rv && rr[k]) begin
                  if (sb[k].size() != 0) void'(sb[k].pop_front());
                  busy[k] = 0;
                  xfers[k]++;
               end else if (!busy[k] && iv[k]) begin
                  exp_t e;
                  acc_edge[k] = cyc + 1;
                  ea[k] = ia[k];
                  eb[k] = ib[k];
                  busy[k] = 1;
                  e.d = fres(ia[k], ib[k]);
                  e.s = fstat(ia[k], ib[k]);
                  sb[k].push_back(e);
                  if (b2b[k]) begin
                     if (b2b_last[k] >= 0)
                        chk("accept_spacing", k, 32'(acc_edge[k] - b2b_last[k]),
                            32'(lat(k) + 3));
                     b2b_last[k] = acc_edge[k];
                  end else begin
                     b2b_last[k] = -1;
                  end
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_for(input int k, input bit want_ready, input int budget);
      int n = 0;
      while (!(want_ready ? ir[k] : rv[k]) && n < budget) begin
         step(1);
         n++;
      end
      n_chk++;
      if (n >= budget) begin
         n_fail++;
         $display("FAIL wait_%s[%0d]: not seen within %0d cycles",
                  want_ready ? "in_ready" : "res_valid", k, budget);
      end
   endtask

   task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b);
      wait_for(k, 1'b1, 100);
      ia[k] = a;
      ib[k] = b;
      iv[k] = 1'b1;
      step(1);
      iv[k] = 1'b0;
   endtask

   task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b);
      issue(k, a, b);
      rr[k] = 1'b1;
      wait_for(k, 1'b0, 300);
      step(1);
   endtask

   task automatic random_phase(input int k, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         iv[k] = ($urandom_range(0, 3) == 0);
         rr[k] = ($urandom_range(0, 1) == 1);
         ia[k] = $urandom;
         ib[k] = $urandom;
         step(1);
      end
      iv[k] = 1'b0;
      rr[k] = 1'b1;
      wait_for(k, 1'b1, 100);
   endtask

   task automatic b2b_phase(input int k, input int cycles);
      b2b[k] = 1'b1;
      iv[k] = 1'b1;
      rr[k] = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         ia[k] = $urandom;
         ib[k] = $urandom;
         step(1);
      end
      iv[k] = 1'b0;
      b2b[k] = 1'b0;
      wait_for(k, 1'b1, 100);
   endtask

   task automatic pulse_reset(input int k);
      rst[k] = 1'b1;
      step(1);
      rst[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         rst[k] = 1'b0; iv[k] = 1'b0; rr[k] = 1'b0;
         ia[k] = '0; ib[k] = '0; fcnt[k] = 0;
      end
      #1;
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      step(3);
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      // Directed 1.0 and 2.0 pair at LATENCY=16.
      run_op(0, 32'h3E000000, 32'h40000000);
      step(2);

      // Result held 10 cycles with in_valid noise.
      rr[0] = 1'b0;
      issue(0, $urandom, $urandom);
      wait_for(0, 1'b0, 100);
      for (int i = 0; i < 10; i++) begin
         iv[0] = i[0];
         ia[0] = $urandom;
         ib[0] = $urandom;
         step(1);
      end
      iv[0] = 1'b0;
      rr[0] = 1'b1;
      step(2);

      b2b_phase(0, 4 * 19 + 3);
      random_phase(0, 400);

      // Three completed transfers then one aborted mid-wait.
      pulse_reset(0);
      for (int i = 0; i < 3; i++) run_op(0, $urandom, $urandom);
      rr[0] = 1'b1;
      step(2);
`ifdef FPU_SEQ_OPCNT_EN
      chk("op_count_before_abort", 0, 32'(oc[0]), 32'd3);
`endif
      issue(0, 32'h12345678, 32'h9ABCDEF0);
      step(6);
      pulse_reset(0);
`ifdef FPU_SEQ_OPCNT_EN
      chk("op_count_after_abort", 0, 32'(oc[0]), 32'd0);
`endif
      step(30);
      run_op(0, $urandom, $urandom);

      // LATENCY=1 instance.
      run_op(1, 32'h3E000000, 32'h40000000);
      step(2);
      run_op(1, $urandom, $urandom);
      b2b_phase(1, 4 * 4 + 2);
      random_phase(1, 200);
      issue(1, $urandom, $urandom);
      pulse_reset(1);
      step(5);

      for (int k = 0; k < N; k++)
         chk("scoreboard_drained", k, 32'(sb[k].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fpu_op_sequencer.md
FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 Parameter LATENCY, default 16: FPU compute latency in clock_100kHz cycles; legal range 1..255.
REQ-002 clock_100kHz  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  sequencer can accept an operand pair.
REQ-006 in_op_a  input  32  operand A: {sign, exp[5:0] bias 31, man[24:0]}.
REQ-007 in_op_b  input  32  operand B, same format.
REQ-008 fpu_op_a  output  32  drives FPU Op_A_in.
REQ-009 fpu_op_b  output  32  drives FPU Op_B_in.
REQ-010 fpu_start  output  1  one-cycle pulse marking a new FPU operation.
REQ-011 fpu_data_in  input  32  FPU data_out.
REQ-012 fpu_status_in  input  4  FPU status_out.
REQ-013 res_valid  output  1  captured result available.
REQ-014 res_ready  input  1  consumer accepts result.
REQ-015 res_data  output  32  captured FPU result.
REQ-016 res_status  output  4  captured FPU status.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-018 in_ready SHALL be 1 exactly when state is IDLE and reset is low.
REQ-019 IDLE: on an edge with in_valid=1 and in_ready=1, register in_op_a/in_op_b into fpu_op_a/fpu_op_b and go to ISSUE.
REQ-020 ISSUE: fpu_start=1 for this single cycle; load the 8-bit wait counter with LATENCY-1; go to WAIT.
REQ-021 WAIT: counter nonzero -> decrement; counter zero -> capture fpu_data_in/fpu_status_in into res_data/res_status and go to HOLD.
REQ-022 res_valid SHALL be high exactly LATENCY+1 rising edges after the acceptance edge.
REQ-023 HOLD: res_valid=1; res_data/res_status stable; on an edge with res_ready=1 go to IDLE, res_valid low next cycle.
REQ-024 fpu_op_a/fpu_op_b SHALL hold their value from acceptance until the next acceptance, including through HOLD and IDLE.
REQ-025 in_valid outside IDLE and res_ready outside HOLD SHALL be ignored; no operand or result is lost or duplicated.
REQ-026 res_ready held high continuously SHALL yield exactly one result transfer per operation; minimum spacing between acceptances is LATENCY+3 edges.
REQ-027 fpu_start SHALL be 0 in all states other than ISSUE.

Reset
REQ-028 While reset is high: state IDLE, in_ready=0, fpu_start=0, res_valid=0, fpu_op_a, fpu_op_b, res_data and res_status all zero, counter zero.
REQ-029 Reset asserted mid-operation SHALL abort the operation immediately; no res_valid is produced for the aborted pair.
REQ-030 First edge after reset deassertion SHALL see in_ready=1.

Configuration
REQ-031 Macro FPU_SEQ_OPCNT_EN defined: add output op_count (16 bits), reset to 0, incremented on each result transfer (HOLD and res_ready), saturating at 16'hFFFF.
REQ-032 Macro FPU_SEQ_OPCNT_EN undefined: op_count port and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-033 Shared package fpu_pkg SHALL hold: fp_word_t struct (sign, exp[5:0], man[24:0]), FP_EXP_BIAS=31, FP_STATUS_W=4, and the sequencer state enum.
REQ-034 The wait counter SHALL be a sub-module fpu_seq_timer (load, decrement, zero flag); everything else stays in fpu_op_sequencer.

Verification
REQ-035 Reset pulse mid-WAIT -> all outputs zero within the reset cycle, no res_valid afterwards, in_ready=1 after release.
REQ-036 LATENCY=16, in_op_a=32'h3E000000 (1.0), in_op_b=32'h40000000 (2.0), FPU model returns 32'h40800000/4'h0 -> fpu_start one pulse one cycle after acceptance, res_valid at edge 17, res_data=32'h40800000.
REQ-037 res_ready held low for 10 cycles in HOLD -> res_valid, res_data, res_status stable; in_valid pulses ignored, in_ready=0.
REQ-038 Back-to-back pairs with in_valid and res_ready tied high -> exactly one fpu_start per pair, results in order, acceptance spacing 19 edges at LATENCY=16.
REQ-039 LATENCY=1 -> res_valid at edge 2 after acceptance, data captured from the cycle after fpu_start.
REQ-040 FPU_SEQ_OPCNT_EN defined, 3 completed transfers plus 1 aborted by reset -> op_count=3 before the reset, 0 after it.
